// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multicycle RV32I core. Sits beside data_path and
//   drives every data_path control input from the decoded instruction fields
//   and the ALU flags. Sequences fetch/decode/execute/memory/writeback for
//   R-type, I-type ALU, lw, sw, branches, jal, jalr and lui, and counts retired
//   instructions.
//
//   Build option: ILLEGAL_TRAP_EN
//     defined   -> an illegal instruction parks the FSM in BAD and raises the
//                  sticky 'illegal' flag until rst.
//     undefined -> BAD is a one-cycle NOP back to FETCH; 'illegal' is tied 0.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   opcode/func3/func7  decoded instruction fields (held stable by the IR)
//   zer, neg            ALU flags for the current cycle (branch decision)
//   pcen                PC load enable (Mealy in BRANCH only)
//   adrsrc              memory address select: 0=PC, 1=ALUOut
//   memwrite            memory write enable
//   irwrite             IR/OLDPC load enable
//   regwrite            register file write enable
//   alusrca             00=PC, 01=OLDPC, 10=A, 11=0
//   alusrcb             00=B, 01=imm, 10=4, 11=0
//   aluop               000 add, 001 sub, 010 and, 011 or, 100 slt, 101 sltu, 110 xor
//   resultsrc           00=ALUOut, 01=ALU result, 10=MDR, 11=imm
//   immsrc              000 I, 001 S, 010 B, 011 J, 100 U
//   instret             retired-instruction count, wraps modulo 2^CNT_W
//   illegal             sticky illegal-instruction flag
//
// The current state is held in the enum signal 'state' for checker binding.
// All outputs are decoded combinationally from 'state'; the enables are
// forced low while rst is high so no write can happen in a reset cycle.

module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic             zer,
    input  logic             neg,
    output logic             pcen,
    output logic             adrsrc,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regwrite,
    output logic [1:0]       alusrca,
    output logic [1:0]       alusrcb,
    output logic [2:0]       aluop,
    output logic [1:0]       resultsrc,
    output logic [2:0]       immsrc,
    output logic [CNT_W-1:0] instret,
    output logic             illegal
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI,
        ALUWB, BRANCH, JAL, JALR, JALRPC, LUI, BAD
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_SLTU = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;

    state_t state;
    state_t state_next;

    // func3 -> ALU operation shared by R and I forms; shifts are unsupported.
    logic [2:0] f3_aluop;
    logic       f3_legal;
    logic [2:0] r_aluop;
    logic       r_legal;
    logic       br_take;
    logic       br_legal;

    always_comb begin
        f3_aluop = ALU_ADD;
        f3_legal = 1'b1;
        case (func3)
            3'b000:  f3_aluop = ALU_ADD;
            3'b111:  f3_aluop = ALU_AND;
            3'b110:  f3_aluop = ALU_OR;
            3'b010:  f3_aluop = ALU_SLT;
            3'b011:  f3_aluop = ALU_SLTU;
            3'b100:  f3_aluop = ALU_XOR;
            default: f3_legal = 1'b0;
        endcase
    end

    // R-type: func7 must be zero except for sub (func3=000, func7=0100000).
    always_comb begin
        r_aluop = f3_aluop;
        r_legal = f3_legal && (func7 == 7'b0000000);
        if (func3 == 3'b000 && func7 == 7'b0100000) begin
            r_aluop = ALU_SUB;
            r_legal = 1'b1;
        end
    end

    always_comb begin
        br_take  = 1'b0;
        br_legal = 1'b1;
        case (func3)
            3'b000:  br_take = zer;
            3'b001:  br_take = ~zer;
            3'b100:  br_take = neg;
            3'b101:  br_take = ~neg;
            default: br_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:  state_next = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = MEMADR;
                    OP_R:              state_next = EXECR;
                    OP_I:              state_next = EXECI;
                    OP_BRANCH:         state_next = BRANCH;
                    OP_JAL:            state_next = JAL;
                    OP_JALR:           state_next = JALR;
                    OP_LUI:            state_next = LUI;
                    default:           state_next = BAD;
                endcase
            end
            MEMADR:   state_next = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  state_next = MEMWB;
            MEMWB:    state_next = FETCH;
            MEMWRITE: state_next = FETCH;
            EXECR:    state_next = r_legal ? ALUWB : BAD;
            EXECI:    state_next = f3_legal ? ALUWB : BAD;
            ALUWB:    state_next = FETCH;
            BRANCH:   state_next = br_legal ? FETCH : BAD;
            JAL:      state_next = ALUWB;
            JALR:     state_next = JALRPC;
            JALRPC:   state_next = ALUWB;
            LUI:      state_next = FETCH;
`ifdef ILLEGAL_TRAP_EN
            BAD:      state_next = BAD;
`else
            BAD:      state_next = FETCH;
`endif
            default:  state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            instret <= '0;
        end else begin
            state <= state_next;
            // An instruction retires whenever the FSM re-enters FETCH.
            if (state_next == FETCH && state != FETCH)
                instret <= instret + CNT_W'(1);
        end
    end

`ifdef ILLEGAL_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst)
            illegal <= 1'b0;
        else if (state == BAD)
            illegal <= 1'b1;
    end
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        pcen      = 1'b0;
        adrsrc    = 1'b0;
        memwrite  = 1'b0;
        irwrite   = 1'b0;
        regwrite  = 1'b0;
        alusrca   = 2'b00;
        alusrcb   = 2'b00;
        aluop     = ALU_ADD;
        resultsrc = 2'b00;
        immsrc    = 3'b000;
        case (state)
            FETCH: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b01;
                pcen      = 1'b1;
            end
            DECODE: begin
                // Precompute the branch/jal target into ALUOut.
                alusrca = 2'b01;
                alusrcb = 2'b01;
                immsrc  = (opcode == OP_JAL) ? 3'b011 : 3'b010;
            end
            MEMADR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                immsrc  = (opcode == OP_STORE) ? 3'b001 : 3'b000;
            end
            MEMREAD:  adrsrc = 1'b1;
            MEMWB: begin
                resultsrc = 2'b10;
                regwrite  = 1'b1;
            end
            MEMWRITE: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
            end
            EXECR: begin
                alusrca = 2'b10;
                aluop   = r_legal ? r_aluop : ALU_ADD;
            end
            EXECI: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                aluop   = f3_legal ? f3_aluop : ALU_ADD;
            end
            ALUWB:    regwrite = 1'b1;
            BRANCH: begin
                alusrca = 2'b10;
                aluop   = ALU_SUB;
                pcen    = br_legal & br_take;
            end
            JAL, JALRPC: begin
                // PC <= target held in ALUOut while the ALU forms OLDPC+4 for rd.
                pcen    = 1'b1;
                alusrca = 2'b01;
                alusrcb = 2'b10;
            end
            JALR: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
            end
            LUI: begin
                immsrc    = 3'b100;
                resultsrc = 2'b11;
                regwrite  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pcen     = 1'b0;
            memwrite = 1'b0;
            irwrite  = 1'b0;
            regwrite = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller. The driver pushes one expected record per
// clock cycle; the monitor pops and compares on the falling edge.
// CNT_W is reduced to 4 so instret wrap is reachable.

module tb_multicycle_controller;

    localparam int CNT_W = 4;
    localparam int CW    = 17;
    localparam int EW    = CW + CNT_W + 1;

    logic             clk;
    logic             rst;
    logic [6:0]       opcode;
    logic [2:0]       func3;
    logic [6:0]       func7;
    logic             zer;
    logic             neg;
    logic             pcen, adrsrc, memwrite, irwrite, regwrite;
    logic [1:0]       alusrca, alusrcb, resultsrc;
    logic [2:0]       aluop, immsrc;
    logic [CNT_W-1:0] instret;
    logic             illegal;

    multicycle_controller #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .zer(zer), .neg(neg), .pcen(pcen), .adrsrc(adrsrc), .memwrite(memwrite),
        .irwrite(irwrite), .regwrite(regwrite), .alusrca(alusrca),
        .alusrcb(alusrcb), .aluop(aluop), .resultsrc(resultsrc),
        .immsrc(immsrc), .instret(instret), .illegal(illegal)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [EW-1:0]    exp_q[$];
    string            name_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] ir_exp = '0;
    logic             il_exp = 1'b0;

    logic [CW-1:0] act_ctrl;
    assign act_ctrl = {pcen, adrsrc, memwrite, irwrite, regwrite,
                       alusrca, alusrcb, aluop, resultsrc, immsrc};

    function automatic logic [CW-1:0] cv(input logic p, input logic ad,
        input logic mw, input logic iw, input logic rw, input logic [1:0] a,
        input logic [1:0] b, input logic [2:0] op, input logic [1:0] rs,
        input logic [2:0] im);
        return {p, ad, mw, iw, rw, a, b, op, rs, im};
    endfunction

    // hand-written expected control words per state
    function automatic logic [CW-1:0] e_fetch();      return cv(1,0,0,1,0,2'b00,2'b10,3'b000,2'b01,3'b000); endfunction
    function automatic logic [CW-1:0] e_decode(input logic j);
        return cv(0,0,0,0,0,2'b01,2'b01,3'b000,2'b00, j ? 3'b011 : 3'b010);
    endfunction
    function automatic logic [CW-1:0] e_memadr(input logic s);
        return cv(0,0,0,0,0,2'b10,2'b01,3'b000,2'b00, s ? 3'b001 : 3'b000);
    endfunction
    function automatic logic [CW-1:0] e_memread();    return cv(0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_memwb();      return cv(0,0,0,0,1,2'b00,2'b00,3'b000,2'b10,3'b000); endfunction
    function automatic logic [CW-1:0] e_memwrite();   return cv(0,1,1,0,0,2'b00,2'b00,3'b000,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_execr(input logic [2:0] op); return cv(0,0,0,0,0,2'b10,2'b00,op,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_execi(input logic [2:0] op); return cv(0,0,0,0,0,2'b10,2'b01,op,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_aluwb();      return cv(0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_branch(input logic p); return cv(p,0,0,0,0,2'b10,2'b00,3'b001,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_jal();        return cv(1,0,0,0,0,2'b01,2'b10,3'b000,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_jalr();       return cv(0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,3'b000); endfunction
    function automatic logic [CW-1:0] e_lui();        return cv(0,0,0,0,1,2'b00,2'b00,3'b000,2'b11,3'b100); endfunction
    function automatic logic [CW-1:0] e_zero();       return '0; endfunction

    // driver tasks: called just after a rising edge; inputs set beforehand
    task automatic cyc(input logic [CW-1:0] c, input string nm);
        exp_q.push_back({c, ir_exp, il_exp});
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic retire();
        ir_exp = ir_exp + 1'b1;
    endtask

    task automatic r_instr(input logic [2:0] f3, input logic [6:0] f7,
                           input logic [2:0] op, input string nm);
        opcode = 7'b0110011; func3 = f3; func7 = f7;
        cyc(e_fetch(), {nm, "_fetch"});
        cyc(e_decode(0), {nm, "_decode"});
        cyc(e_execr(op), {nm, "_execr"});
        cyc(e_aluwb(), {nm, "_aluwb"});
        retire();
    endtask

    task automatic i_instr(input logic [2:0] f3, input logic [2:0] op, input string nm);
        opcode = 7'b0010011; func3 = f3; func7 = 7'b0100000;
        cyc(e_fetch(), {nm, "_fetch"});
        cyc(e_decode(0), {nm, "_decode"});
        cyc(e_execi(op), {nm, "_execi"});
        cyc(e_aluwb(), {nm, "_aluwb"});
        retire();
    endtask

    task automatic br_instr(input logic [2:0] f3, input logic z, input logic n,
                            input logic take, input string nm);
        opcode = 7'b1100011; func3 = f3; func7 = 7'b0; zer = z; neg = n;
        cyc(e_fetch(), {nm, "_fetch"});
        cyc(e_decode(0), {nm, "_decode"});
        cyc(e_branch(take), {nm, "_branch"});
        retire();
        zer = 1'b0; neg = 1'b0;
    endtask

    task automatic lui_instr(input string nm);
        opcode = 7'b0110111; func3 = 3'b000; func7 = 7'b0;
        cyc(e_fetch(), {nm, "_fetch"});
        cyc(e_decode(0), {nm, "_decode"});
        cyc(e_lui(), {nm, "_lui"});
        retire();
    endtask

    // Entered after FETCH/DECODE (and BRANCH) of an illegal instruction.
    task automatic bad_tail(input string nm);
`ifdef ILLEGAL_TRAP_EN
        cyc(e_zero(), {nm, "_bad"});
        il_exp = 1'b1;
        cyc(e_zero(), {nm, "_stuck1"});
        cyc(e_zero(), {nm, "_stuck2"});
        rst = 1'b1;
        cyc(e_zero(), {nm, "_rst"});
        rst = 1'b0;
        ir_exp = '0;
        il_exp = 1'b0;
`else
        cyc(e_zero(), {nm, "_bad"});
        retire();
`endif
    endtask

    // monitor
    initial begin : monitor
        logic [EW-1:0] e;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                checks++;
                if (act_ctrl !== e[EW-1 -: CW]) begin
                    errors++;
                    $display("FAIL %s ctrl got %05h expected %05h", nm, act_ctrl, e[EW-1 -: CW]);
                end
                checks++;
                if (instret !== e[CNT_W:1]) begin
                    errors++;
                    $display("FAIL %s instret got %0d expected %0d", nm, instret, e[CNT_W:1]);
                end
                checks++;
                if (illegal !== e[0]) begin
                    errors++;
                    $display("FAIL %s illegal got %b expected %b", nm, illegal, e[0]);
                end
            end
        end
    end

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    // stimulus
    initial begin
        rst = 1'b1; opcode = 7'b0; func3 = 3'b0; func7 = 7'b0; zer = 1'b0; neg = 1'b0;
        @(posedge clk);
        #1;
        // second reset cycle: FETCH decoded but enables held low
        cyc(cv(0,0,0,0,0,2'b00,2'b10,3'b000,2'b01,3'b000), "reset");
        rst = 1'b0;

        r_instr(3'b000, 7'b0000000, 3'b000, "add");
        r_instr(3'b000, 7'b0100000, 3'b001, "sub");
        i_instr(3'b111, 3'b010, "andi");
        r_instr(3'b010, 7'b0000000, 3'b100, "slt");
        i_instr(3'b100, 3'b110, "xori");
        r_instr(3'b110, 7'b0000000, 3'b011, "or");
        i_instr(3'b011, 3'b101, "sltiu");

        // lw x5,8(x1)
        opcode = 7'b0000011; func3 = 3'b010; func7 = 7'b0;
        cyc(e_fetch(), "lw_fetch");
        cyc(e_decode(0), "lw_decode");
        cyc(e_memadr(0), "lw_memadr");
        cyc(e_memread(), "lw_memread");
        cyc(e_memwb(), "lw_memwb");
        retire();

        // sw
        opcode = 7'b0100011; func3 = 3'b010;
        cyc(e_fetch(), "sw_fetch");
        cyc(e_decode(0), "sw_decode");
        cyc(e_memadr(1), "sw_memadr");
        cyc(e_memwrite(), "sw_memwrite");
        retire();

        br_instr(3'b000, 1, 0, 1, "beq_taken");
        br_instr(3'b000, 0, 0, 0, "beq_not");
        br_instr(3'b001, 0, 1, 1, "bne_taken");
        br_instr(3'b100, 0, 1, 1, "blt_taken");
        br_instr(3'b101, 1, 1, 0, "bge_not");

        // jal
        opcode = 7'b1101111; func3 = 3'b000;
        cyc(e_fetch(), "jal_fetch");
        cyc(e_decode(1), "jal_decode");
        cyc(e_jal(), "jal_jal");
        cyc(e_aluwb(), "jal_aluwb");
        retire();

        // jalr: this retirement takes the 4-bit counter from 15 to 0
        opcode = 7'b1100111; func3 = 3'b000;
        cyc(e_fetch(), "jalr_fetch");
        cyc(e_decode(0), "jalr_decode");
        cyc(e_jalr(), "jalr_jalr");
        cyc(e_jalrpc_wrap(), "jalr_jalrpc");
        cyc(e_aluwb(), "jalr_aluwb");
        retire();

        lui_instr("lui_after_wrap");

        // branch with unsupported func3: no PC write even with zer/neg set
        opcode = 7'b1100011; func3 = 3'b010; zer = 1'b1; neg = 1'b1;
        cyc(e_fetch(), "badbr_fetch");
        cyc(e_decode(0), "badbr_decode");
        cyc(e_branch(0), "badbr_branch");
        zer = 1'b0; neg = 1'b0;
        bad_tail("badbr");

        // unknown opcode
        opcode = 7'b1111111; func3 = 3'b000;
        cyc(e_fetch(), "badop_fetch");
        cyc(e_decode(0), "badop_decode");
        bad_tail("badop");

        lui_instr("lui_after_bad");

        // reset in MEMWB of a lw: regwrite must stay low, instret clears
        opcode = 7'b0000011; func3 = 3'b010;
        cyc(e_fetch(), "lwrst_fetch");
        cyc(e_decode(0), "lwrst_decode");
        cyc(e_memadr(0), "lwrst_memadr");
        cyc(e_memread(), "lwrst_memread");
        rst = 1'b1;
        cyc(cv(0,0,0,0,0,2'b00,2'b00,3'b000,2'b10,3'b000), "lwrst_memwb_rst");
        rst = 1'b0;
        ir_exp = '0;

        lui_instr("lui_after_rst");

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain left %0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    function automatic logic [CW-1:0] e_jalrpc_wrap();
        return cv(1,0,0,0,0,2'b01,2'b10,3'b000,2'b00,3'b000);
    endfunction

endmodule
